pc_unit: RTL

Program-counter stage at the head of the pipeline. It holds the PC, computes the next fetch address (sequential, branch or jump), and applies hazard stalls and debug single-step gating. It drives the address input of `instruction_fetch` and detects the HALT word that `instruction_fetch` returns, which freezes the front end.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/pc_unit_if.sv | 30 +++
 rtl/pc_next_select.sv | 50 +++++
 rtl/pc_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: HALT encoding, PC state encoding, reset PC.
package pipeline_pkg;

  localparam logic [31:0] HALT_WORD        = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Front-end bus between pc_unit (slave) and the surrounding pipeline (master).
interface pc_unit_if #(
  parameter int B = 32
);
  logic         stall;
  logic         branch_taken;
  logic [B-1:0] branch_target;
  logic         jump;
  logic [B-1:0] jump_target;
  logic         step_mode;
  logic         step;
  logic [31:0]  instruction;
  logic [B-1:0] pc;
  logic [B-1:0] pc_plus4;
  logic         advance;
  logic         halted;
  logic [31:0]  fetch_count;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           step_mode, step, instruction,
    input  pc, pc_plus4, advance, halted, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           step_mode, step, instruction,
    output pc, pc_plus4, advance, halted, fetch_count
  );
endinterface

// File: rtl/pc_next_select.sv
// Combinational priority mux: next PC, next state and advance for this cycle.
module pc_next_select
  import pipeline_pkg::*;
#(
  parameter int B = 32
) (
  input  pc_state_e    state,
  input  logic [B-1:0] pc,
  input  logic [B-1:0] pc_plus4,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [B-1:0] branch_target,
  input  logic         jump,
  input  logic [B-1:0] jump_target,
  input  logic         step_mode,
  input  logic         step,
  input  logic [31:0]  instruction,
  output pc_state_e    state_next,
  output logic [B-1:0] pc_next,
  output logic         advance
);

  logic gate;
  assign gate = ~step_mode | step;

  // Priority: gate, branch (older instr) over jump, stall, HALT, sequential.
  always_comb begin
    pc_next    = pc;
    state_next = state;
    advance    = 1'b0;
    if (state == PC_RUN && gate) begin
      if (branch_taken) begin
        pc_next = branch_target & ~B'(3);
        advance = 1'b1;
      end else if (jump) begin
        pc_next = jump_target & ~B'(3);
        advance = 1'b1;
      end else if (stall) begin
        // hold; a HALT presented now is re-evaluated once the stall clears
        pc_next = pc;
      end else if (instruction == HALT_WORD) begin
        state_next = PC_HALTED;
      end else begin
        pc_next = pc_plus4;
        advance = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage. Optional accepted-fetch counter: PC_FETCH_COUNTER_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// PC_RUN    | fetching: hold / redirect / step / sequential per cycle
// PC_HALTED | HALT accepted, PC frozen; only reset leaves this state
module pc_unit
  import pipeline_pkg::*;
#(
  parameter int           B        = 32,
  parameter logic [B-1:0] PC_RESET = B'(PC_RESET_DEFAULT)
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  pc_state_e    state_q, state_d;
  logic [B-1:0] pc_q, pc_d;
  logic         halted_q, halted_d;
  logic [B-1:0] pc_plus4;
  logic         advance;

  assign pc_plus4 = pc_q + B'(4);

  pc_next_select #(.B(B)) u_next (
    .state         (state_q),
    .pc            (pc_q),
    .pc_plus4      (pc_plus4),
    .stall         (bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .step_mode     (bus.step_mode),
    .step          (bus.step),
    .instruction   (bus.instruction),
    .state_next    (state_d),
    .pc_next       (pc_d),
    .advance       (advance)
  );

  // halted is a registered copy of the next state
  always_comb begin
    halted_d = (state_d == PC_HALTED);
  end

  // FSM state, PC and halted flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PC_RUN;
      pc_q     <= PC_RESET;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.advance  = advance;
  assign bus.halted   = halted_q;

`ifdef PC_FETCH_COUNTER_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // saturating count of cycles in which the front end advanced
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (advance && fetch_count_q != 32'hFFFF_FFFF)
      fetch_count_d = fetch_count_q + 32'd1;
  end

  // fetch counter register
  always_ff @(posedge clk) begin
    if (reset) fetch_count_q <= 32'd0;
    else       fetch_count_q <= fetch_count_d;
  end

  assign bus.fetch_count = fetch_count_q;
`else
  assign bus.fetch_count = 32'd0;
`endif

endmodule
